local_bht_history_table: RTL
============================

LOCAL_BHT_HISTORY_TABLE -- requirements
Module: local_bht_history_table

Interface
REQ-001 Parameter WIDTH, default 8: bits of local history per entry (>=2).
REQ-002 Parameter DEPTH, default 64: number of entries (power of two, >=4); localparam IDX_W = clog2(DEPTH).
REQ-003 Parameter NUM_RD, default 2: number of independent read ports (>=1).
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 flush  in  1  request to clear every entry (pipeline/context flush).
REQ-007 ready  out  1  high when table is idle and accepting updates.
REQ-008 rd_index  in  NUM_RD*IDX_W  packed read indices, port p at [p*IDX_W +: IDX_W].
REQ-009 rd_data  out  NUM_RD*WIDTH  packed read histories, port p at [p*WIDTH +: WIDTH].
REQ-010 upd_valid  in  1  update strobe.
REQ-011 upd_mode  in  1  0 = shift in outcome, 1 = load full pattern.
REQ-012 upd_index  in  IDX_W  entry to update.
REQ-013 upd_taken  in  1  branch outcome shifted in when upd_mode=0.
REQ-014 upd_data  in  WIDTH  pattern loaded when upd_mode=1 (misprediction repair).
REQ-015 upd_old  out  WIDTH  current stored value at upd_index (combinational).

Function
REQ-016 Controller states: CLEAR, IDLE; ready = (state==IDLE).
REQ-017 In CLEAR, each cycle writes zero to entry clr_ptr and increments clr_ptr; after entry DEPTH-1 is written the state becomes IDLE.
REQ-018 Sweep takes exactly DEPTH cycles; ready rises on the DEPTH-th rising edge after reset release or flush sample.
REQ-019 flush sampled high in IDLE: next state CLEAR, clr_ptr=0; flush sampled in CLEAR: clr_ptr restarts at 0.
REQ-020 Update accepted iff upd_valid && ready && !flush; otherwise dropped silently (no queuing).
REQ-021 Accepted shift update: entry <= {entry[WIDTH-2:0], upd_taken}, MSB discarded.
REQ-022 Accepted load update: entry <= upd_data.
REQ-023 Read ports are combinational, mutually independent, may alias any index including each other and upd_index.
REQ-024 While state==CLEAR every rd_data port and upd_old return zero.
REQ-025 Stored entry visible on reads the cycle after the accepting edge.

Reset
REQ-026 rst_n low: state=CLEAR, clr_ptr=0, ready=0 immediately; array contents are not reset directly but cleared by the sweep.
REQ-027 rst_n asserted mid-sweep or mid-operation restarts the sweep from entry 0 after release.

Configuration
REQ-028 Macro LOCAL_BHT_BYPASS_EN defined: any read port whose index equals upd_index during an accepted update returns the post-update value in that same cycle.
REQ-029 LOCAL_BHT_BYPASS_EN undefined: such a read returns the pre-update stored value; no bypass logic instantiated.

Structure
REQ-030 Clear-state enum type lc3b_bht_clr_state_t and default WIDTH/DEPTH constants SHALL live in lc3b_types.
REQ-031 Sweep controller (state, clr_ptr, ready) SHALL be sub-module local_bht_clear_ctrl; storage, update and read muxing stay in the top.

Verification
REQ-032 Release rst_n, hold flush=0 -> ready=0 for 64 cycles, ready=1 on cycle 64, all reads 0x00.
REQ-033 Shift taken=1,1,0 into index 5 (three accepted cycles) -> rd_data port0 idx5 = 0x06, upd_old idx5 = 0x06.
REQ-034 Load upd_data=0xA5 at index 63, then shift taken=1 -> reads 0x4B; index 0 unaffected 0x00.
REQ-035 Update index 9 with both ports reading index 9 -> bypass build returns new value same cycle; non-bypass build returns old, new next cycle.
REQ-036 flush and upd_valid same cycle at index 3 holding 0x0F -> update dropped, ready low 64 cycles, idx3 reads 0x00 afterwards.
REQ-037 Assert rst_n low at sweep cycle 30 -> after release, ready stays low a full 64 cycles; updates during sweep ignored.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared types and default sizing for the local branch-history table.
package lc3b_types;

  localparam int unsigned BHT_WIDTH = 8;
  localparam int unsigned BHT_DEPTH = 64;

  // The controller is either sweeping zeros through the array or serving updates.
  typedef enum logic {
    BHT_CLR_CLEAR = 1'b0,
    BHT_CLR_IDLE  = 1'b1
  } lc3b_bht_clr_state_t;

endpackage

// File: rtl/local_bht_clear_ctrl.sv
// Clear-sweep controller: after reset or flush, walks clr_ptr over every entry
// once, then raises ready.
module local_bht_clear_ctrl
  import lc3b_types::*;
#(
  parameter int unsigned DEPTH = BHT_DEPTH,
  parameter int unsigned IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush_i,
  output logic             ready_o,
  output logic [IDX_W-1:0] clr_ptr_o
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

  lc3b_bht_clr_state_t state_q, state_d;
  logic [IDX_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic                ready_q;

  // Next-state logic: a flush in either state restarts the sweep at entry 0.
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    unique case (state_q)
      BHT_CLR_CLEAR: begin
        if (flush_i) begin
          clr_ptr_d = '0;
        end else if (clr_ptr_q == LAST_IDX) begin
          state_d   = BHT_CLR_IDLE;
          clr_ptr_d = '0;
        end else begin
          clr_ptr_d = clr_ptr_q + IDX_W'(1);
        end
      end
      BHT_CLR_IDLE: begin
        if (flush_i) begin
          state_d   = BHT_CLR_CLEAR;
          clr_ptr_d = '0;
        end
      end
      default: begin
        state_d   = BHT_CLR_CLEAR;
        clr_ptr_d = '0;
      end
    endcase
  end

  // State, sweep pointer and ready flop; reset lands in CLEAR with ready low.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= BHT_CLR_CLEAR;
      clr_ptr_q <= '0;
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= (state_d == BHT_CLR_IDLE);
    end
  end

  assign ready_o   = ready_q;
  assign clr_ptr_o = clr_ptr_q;

endmodule

// File: rtl/local_bht_history_table.sv
// Per-branch local history table with shift/load updates, NUM_RD combinational
// read ports and a zeroing sweep after reset or flush.
// Build option: define LOCAL_BHT_BYPASS_EN to forward an accepted update to
// same-index reads in the same cycle; otherwise reads show the stored value.
module local_bht_history_table
  import lc3b_types::*;
#(
  parameter int unsigned WIDTH  = BHT_WIDTH,
  parameter int unsigned DEPTH  = BHT_DEPTH,
  parameter int unsigned NUM_RD = 2,
  parameter int unsigned IDX_W  = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    flush,
  output logic                    ready,
  input  logic [NUM_RD*IDX_W-1:0] rd_index,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  input  logic                    upd_valid,
  input  logic                    upd_mode,
  input  logic [IDX_W-1:0]        upd_index,
  input  logic                    upd_taken,
  input  logic [WIDTH-1:0]        upd_data,
  output logic [WIDTH-1:0]        upd_old
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [IDX_W-1:0] clr_ptr;
  logic [WIDTH-1:0] upd_cur_c;
  logic [WIDTH-1:0] upd_new_c;
  logic             upd_acc_c;

  local_bht_clear_ctrl #(
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) u_clear_ctrl (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush_i   (flush),
    .ready_o   (ready),
    .clr_ptr_o (clr_ptr)
  );

  assign upd_acc_c = upd_valid && ready && !flush;
  assign upd_cur_c = mem_q[upd_index];
  assign upd_new_c = upd_mode ? upd_data : {upd_cur_c[WIDTH-2:0], upd_taken};
  assign upd_old   = ready ? upd_cur_c : '0;

  // Storage: the sweep owns the write port while not ready, updates otherwise.
  always_ff @(posedge clk) begin
    if (!ready) begin
      mem_q[clr_ptr] <= '0;
    end else if (upd_acc_c) begin
      mem_q[upd_index] <= upd_new_c;
    end
  end

  for (genvar p = 0; p < int'(NUM_RD); p++) begin : g_rd
    logic [IDX_W-1:0] idx_c;
    assign idx_c = rd_index[p*IDX_W +: IDX_W];
`ifdef LOCAL_BHT_BYPASS_EN
    assign rd_data[p*WIDTH +: WIDTH] = !ready ? '0 :
                                       (upd_acc_c && (idx_c == upd_index)) ? upd_new_c :
                                       mem_q[idx_c];
`else
    assign rd_data[p*WIDTH +: WIDTH] = ready ? mem_q[idx_c] : '0;
`endif
  end

endmodule
